// File: rtl/score_pkg.sv
// score_pkg: shared definitions for the dinosaur-game score engine.
//   state_t       : game FSM encodings (IDLE/RUN/OVER)
//   BCD_MAX       : saturating value of the 4-digit packed BCD score
//   BCD_DIGIT_MAX : largest legal BCD digit
//   clog2()       : width helper for the score prescaler
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [15:0] BCD_MAX       = 16'h9999;
  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter4.sv
// bcd_counter4: 4-digit packed BCD up-counter that saturates at 9999.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (priority over inc)
//   inc        : add one in BCD on this edge
//   q[15:0]    : {thousands, hundreds, tens, ones}
//   at_max     : high while q == 9999
module bcd_counter4
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        at_max
);

  logic [15:0] r_q;
  logic [15:0] w_next;
  logic        w_carry;

  // Ripple the +1 through the digits; a 9 with carry-in rolls to 0.
  always_comb begin
    w_next  = r_q;
    w_carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_q[4*i +: 4] == BCD_DIGIT_MAX) begin
          w_next[4*i +: 4] = 4'd0;
        end else begin
          w_next[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !at_max) begin
      r_q <= w_next;
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == BCD_MAX);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: game-score engine for the dinosaur game.
// Counts run time as a 4-digit packed BCD score, runs the IDLE/RUN/OVER FSM,
// tracks the best score and derives a speed level.
// Ports:
//   clk, rst_n  : 100 MHz clock, asynchronous active-low reset
//   start       : debounced jump button (rising edge used)
//   collision   : high while the dino overlaps an obstacle
//   score       : packed BCD score
//   hi_score    : packed BCD best score since reset
//   running     : high in RUN
//   game_over   : high in OVER
//   speed_level : min(thousands / SPEED_STEP, 7)
//   saturated   : high while score == 9999
// Build option: define SCORE_HISCORE_EN to include the high-score register;
// otherwise hi_score is tied to zero.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter logic [3:0]  SPEED_STEP = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        collision,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        running,
  output logic        game_over,
  output logic [2:0]  speed_level,
  output logic        saturated
);

  localparam int unsigned PW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_start_q;
  logic          r_running;
  logic          r_game_over;
  logic [2:0]    r_speed;

  logic          w_start_rise;
  logic          w_tick;
  logic          w_clr;
  logic          w_inc;
  logic [15:0]   w_score;
  logic          w_at_max;
  logic [3:0]    w_thou_div;

  assign w_start_rise = start & ~r_start_q;
  assign w_tick       = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  // Score is forced to zero throughout IDLE and on a restart from OVER.
  assign w_clr        = (r_state == ST_IDLE) || ((r_state == ST_OVER) && w_start_rise);
  // A collision on the tick cycle suppresses that point.
  assign w_inc        = w_tick && !collision;

  bcd_counter4 u_score (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .inc    (w_inc),
    .q      (w_score),
    .at_max (w_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_start_q   <= 1'b0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_start_q <= start;
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          if (w_start_rise) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (collision) begin
            r_state     <= ST_OVER;
            r_running   <= 1'b0;
            r_game_over <= 1'b1;
          end
        end
        ST_OVER: begin
          if (w_start_rise) begin
            r_state     <= ST_RUN;
            r_presc     <= '0;
            r_running   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_presc     <= '0;
          r_running   <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign w_thou_div = w_score[15:12] / SPEED_STEP;

  // Registered from the counter output, so it trails a score change by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed <= '0;
    end else if (r_state == ST_IDLE) begin
      r_speed <= '0;
    end else begin
      r_speed <= (w_thou_div > 4'd7) ? 3'd7 : w_thou_div[2:0];
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [15:0] r_hi;

  // Packed BCD orders the same as binary, so a plain compare suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
    end else if ((r_state == ST_RUN) && collision && (w_score > r_hi)) begin
      r_hi <= w_score;
    end
  end

  assign hi_score = r_hi;
`else
  assign hi_score = '0;
`endif

  assign score       = w_score;
  assign running     = r_running;
  assign game_over   = r_game_over;
  assign speed_level = r_speed;
  assign saturated   = w_at_max;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed self-checking bench for score_keeper (TICK_DIV=4).
module tb_score_keeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        collision;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        running;
  logic        game_over;
  logic [2:0]  speed_level;
  logic        saturated;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned bad_nib = 0;
  int unsigned bad_dec = 0;

  score_keeper #(.TICK_DIV(4), .SPEED_STEP(4'd1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .collision   (collision),
    .score       (score),
    .hi_score    (hi_score),
    .running     (running),
    .game_over   (game_over),
    .speed_level (speed_level),
    .saturated   (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) @(negedge clk);
  endtask

  // One-cycle start pulse driven on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_collision();
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (score[4*i +: 4] > 4'd9) bad_nib++;
      end
      if (running && game_over) bad_dec++;
    end
  end

  logic [15:0] hi41, hi42, hi9999;

  initial begin
`ifdef SCORE_HISCORE_EN
    hi41 = 16'h0041; hi42 = 16'h0042; hi9999 = 16'h9999;
`else
    hi41 = 16'h0000; hi42 = 16'h0000; hi9999 = 16'h0000;
`endif
    rst_n = 1'b0; start = 1'b0; collision = 1'b0;
    cyc(2);
    chk("rst_score", score, 16'h0000);
    chk("rst_hi", hi_score, 16'h0000);
    chk("rst_run", {15'd0, running}, 16'd0);
    chk("rst_over", {15'd0, game_over}, 16'd0);
    chk("rst_speed", {13'd0, speed_level}, 16'd0);
    chk("rst_sat", {15'd0, saturated}, 16'd0);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_run", {15'd0, running}, 16'd0);
    chk("idle_score", score, 16'h0000);

    // Start held high from here on through the first game over.
    start = 1'b1;
    cyc(1);
    chk("start_run", {15'd0, running}, 16'd1);
    cyc(40);
    chk("score_40clk", score, 16'h0010);
    cyc(31 * 4 + 3);
    chk("score_41", score, 16'h0041);
    collision = 1'b1;       // prescaler at its last count: tick cycle
    cyc(1);
    chk("coll_over", {15'd0, game_over}, 16'd1);
    chk("coll_run", {15'd0, running}, 16'd0);
    chk("coll_score", score, 16'h0041);
    chk("coll_hi", hi_score, hi41);
    cyc(20);
    chk("held_start_over", {15'd0, game_over}, 16'd1);
    chk("held_start_score", score, 16'h0041);
    start = 1'b0; collision = 1'b0;
    cyc(1);

    // Second run ends lower: high score kept.
    pulse_start();
    chk("restart_clr", score, 16'h0000);
    chk("restart_run", {15'd0, running}, 16'd1);
    cyc(30 * 4);
    chk("score_30", score, 16'h0030);
    pulse_collision();
    chk("run2_score", score, 16'h0030);
    chk("run2_hi", hi_score, hi41);

    // Third run ends higher: high score updated.
    pulse_start();
    cyc(42 * 4);
    chk("score_42", score, 16'h0042);
    pulse_collision();
    chk("run3_hi", hi_score, hi42);
    chk("run3_over", {15'd0, game_over}, 16'd1);

    // Asynchronous reset mid-run.
    pulse_start();
    cyc(123 * 4);
    chk("score_123", score, 16'h0123);
    #2 rst_n = 1'b0;
    #1;
    chk("async_score", score, 16'h0000);
    chk("async_hi", hi_score, 16'h0000);
    chk("async_run", {15'd0, running}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_run", {15'd0, running}, 16'd0);
    chk("post_rst_over", {15'd0, game_over}, 16'd0);

    // BCD carry into thousands and speed level lag.
    pulse_start();
    cyc(999 * 4);
    chk("score_999", score, 16'h0999);
    chk("speed_999", {13'd0, speed_level}, 16'd0);
    cyc(4);
    chk("score_1000", score, 16'h1000);
    chk("speed_lag", {13'd0, speed_level}, 16'd0);
    cyc(1);
    chk("speed_1", {13'd0, speed_level}, 16'd1);
    cyc(800);
    chk("score_1200", score, 16'h1200);
    chk("nibbles_legal", bad_nib[15:0], 16'd0);

    // Saturation.
    cyc(35194);
    chk("score_9998", score, 16'h9998);
    chk("sat_9998", {15'd0, saturated}, 16'd0);
    cyc(2);
    chk("score_9999", score, 16'h9999);
    chk("sat_9999", {15'd0, saturated}, 16'd1);
    chk("speed_7", {13'd0, speed_level}, 16'd7);
    cyc(80);
    chk("sat_hold", score, 16'h9999);
    chk("sat_hold_flag", {15'd0, saturated}, 16'd1);
    pulse_collision();
    chk("sat_hi", hi_score, hi9999);
    chk("nibbles_all", bad_nib[15:0], 16'd0);
    chk("never_both", bad_dec[15:0], 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
